// File: rtl/imm_gen_pkg.sv
// Shared types for the RISC-V immediate generator: format codes, opcodes, entry layout.
// Optional RVC decode is enabled with IMM_GEN_RVC_EN.
package imm_gen_pkg;

   typedef enum logic [3:0] {
      FMT_NONE  = 4'd0,
      FMT_I     = 4'd1,
      FMT_SHAMT = 4'd2,
      FMT_S     = 4'd3,
      FMT_B     = 4'd4,
      FMT_U     = 4'd5,
      FMT_J     = 4'd6,
      FMT_Z     = 4'd7,
      FMT_C     = 4'd8
   } imm_fmt_e;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   localparam int IMM_W_DEF = 64;
   localparam int TAG_W_DEF = 8;

   // Entry layout at the default widths; the top keeps a parametrised twin.
   typedef struct packed {
      logic [IMM_W_DEF-1:0] imm;
      imm_fmt_e             fmt;
      logic                 illegal;
      logic [TAG_W_DEF-1:0] tag;
   } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational instruction -> {imm, fmt, illegal} decode (module imm_decode_core).
// Compressed (RVC) decode is compiled in only when IMM_GEN_RVC_EN is defined.
module imm_decode_core
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] imm_o,
   output logic [3:0]      fmt_o,
   output logic            illegal_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_shift;
   logic [31:0] val;
   imm_fmt_e    fmt;
   logic        ill;

   assign opcode   = instr_i[6:0];
   assign funct3   = instr_i[14:12];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

`ifdef IMM_GEN_RVC_EN
   logic [31:0] rvc_val;
   logic        rvc_ok;

   // RVC immediate scramble, keyed by {quadrant, funct3}
   always_comb begin
      rvc_val = 32'd0;
      rvc_ok  = 1'b1;
      case ({instr_i[1:0], instr_i[15:13]})
         5'b00_000: begin
            rvc_val = {22'd0, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00};
            rvc_ok  = (rvc_val != 32'd0);
         end
         5'b00_010, 5'b00_110: rvc_val = {25'd0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
         5'b00_011, 5'b00_111: rvc_val = {24'd0, instr_i[6:5], instr_i[12:10], 3'b000};
         5'b01_000, 5'b01_010: rvc_val = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
         5'b01_011: begin
            if (instr_i[11:7] == 5'd2) begin
               rvc_val = {{22{instr_i[12]}}, instr_i[12], instr_i[4:3], instr_i[5],
                          instr_i[2], instr_i[6], 4'b0000};
            end else begin
               rvc_val = {{14{instr_i[12]}}, instr_i[12], instr_i[6:2], 12'd0};
            end
            rvc_ok = (rvc_val != 32'd0);
         end
         5'b01_100: begin
            case (instr_i[11:10])
               2'b00, 2'b01: rvc_val = {26'd0, instr_i[12], instr_i[6:2]};
               2'b10:        rvc_val = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
               default:      rvc_ok  = 1'b0;
            endcase
         end
         5'b01_101: rvc_val = {{20{instr_i[12]}}, instr_i[12], instr_i[8], instr_i[10:9],
                               instr_i[6], instr_i[7], instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
         5'b01_110, 5'b01_111: rvc_val = {{23{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2],
                                          instr_i[11:10], instr_i[4:3], 1'b0};
         5'b10_000: rvc_val = {26'd0, instr_i[12], instr_i[6:2]};
         5'b10_010: rvc_val = {24'd0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00};
         5'b10_011: rvc_val = {23'd0, instr_i[4:2], instr_i[12], instr_i[6:5], 3'b000};
         5'b10_110: rvc_val = {24'd0, instr_i[8:7], instr_i[12:9], 2'b00};
         5'b10_111: rvc_val = {23'd0, instr_i[9:7], instr_i[12:10], 3'b000};
         default:   rvc_ok  = 1'b0;
      endcase
   end
`endif

   // 32-bit value is built once and sign-extended/truncated to XLEN at the end
   always_comb begin
      val = 32'd0;
      fmt = FMT_NONE;
      ill = 1'b0;
      if (instr_i[1:0] == 2'b11) begin
         case (opcode)
            OPC_LOAD, OPC_JALR: begin
               fmt = FMT_I;
               val = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
               if (is_shift) begin
                  fmt = FMT_SHAMT;
                  if ((XLEN == 64) && (opcode == OPC_OP_IMM)) begin
                     val = {26'd0, instr_i[25:20]};
                  end else begin
                     val = {27'd0, instr_i[24:20]};
                  end
               end else begin
                  fmt = FMT_I;
                  val = {{20{instr_i[31]}}, instr_i[31:20]};
               end
            end
            OPC_STORE: begin
               fmt = FMT_S;
               val = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
               fmt = FMT_B;
               val = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
               fmt = FMT_U;
               val = {instr_i[31:12], 12'd0};
            end
            OPC_JAL: begin
               fmt = FMT_J;
               val = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
               if (instr_i[14]) begin
                  fmt = FMT_Z;
                  val = {27'd0, instr_i[19:15]};
               end else begin
                  fmt = FMT_NONE;
                  val = 32'd0;
               end
            end
            default: ill = 1'b1;
         endcase
      end else begin
`ifdef IMM_GEN_RVC_EN
         if (rvc_ok) begin
            fmt = FMT_C;
            val = rvc_val;
         end else begin
            ill = 1'b1;
         end
`else
         ill = 1'b1;
`endif
      end
      imm_o     = XLEN'({{32{val[31]}}, val});
      fmt_o     = fmt;
      illegal_o = ill;
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decode core + 2-entry skid buffer, 1-cycle latency.
// Define IMM_GEN_RVC_EN to enable compressed-instruction decode.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [3:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      imm_fmt_e         fmt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } entry_t;

   localparam entry_t ENTRY_RST = '{imm: {XLEN{1'b0}}, fmt: FMT_NONE,
                                    illegal: 1'b0, tag: {TAG_W{1'b0}}};

   // State bits are {skid_valid, main_valid} so both handshake outputs come straight from flops
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_TWO   = 2'b11;

   logic [1:0]      state_q, state_d;
   entry_t          main_q, main_d;
   entry_t          skid_q, skid_d;
   entry_t          dec_entry;
   logic [XLEN-1:0] dec_imm;
   logic [3:0]      dec_fmt;
   logic            dec_illegal;
   logic            accept;
   logic            pop;

   imm_decode_core #(.XLEN(XLEN)) u_decode (
      .instr_i   (in_instr),
      .imm_o     (dec_imm),
      .fmt_o     (dec_fmt),
      .illegal_o (dec_illegal)
   );

   assign dec_entry = '{imm: dec_imm, fmt: imm_fmt_e'(dec_fmt),
                        illegal: dec_illegal, tag: in_tag};

   assign in_ready    = ~state_q[1];
   assign out_valid   = state_q[0];
   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;
   assign out_tag     = main_q.tag;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // Skid-buffer FSM; flush empties it but leaves the output fields as they were
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_d  = dec_entry;
                  state_d = ST_ONE;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  main_d  = dec_entry;
                  state_d = ST_ONE;
               end else if (accept) begin
                  skid_d  = dec_entry;
                  state_d = ST_TWO;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end else begin
                  state_d = ST_TWO;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // State and entry registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= ENTRY_RST;
         skid_q  <= ENTRY_RST;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=64, TAG_W=8); honours IMM_GEN_RVC_EN.
module tb_imm_gen_pipe;
   import imm_gen_pkg::*;

   localparam int XLEN  = 64;
   localparam int TAG_W = 8;
   localparam int NVEC  = 14;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush_i;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [3:0]       out_fmt;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   int errors = 0;
   int checks = 0;

   logic [31:0] v_instr [NVEC];
   logic [63:0] v_imm   [NVEC];
   logic [3:0]  v_fmt   [NVEC];
   logic        v_ill   [NVEC];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm     (out_imm),
      .out_fmt     (out_fmt),
      .out_illegal (out_illegal),
      .out_tag     (out_tag)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'd0; in_tag = 8'd0;
      step(); step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      checks++; if (out_imm !== 64'd0) begin errors++; $display("FAIL reset_out_imm got=%h exp=0", out_imm); end
      checks++; if (out_fmt !== FMT_NONE) begin errors++; $display("FAIL reset_out_fmt got=%0d exp=0", out_fmt); end
      checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_illegal got=%0b exp=0", out_illegal); end
      checks++; if (out_tag !== 8'd0) begin errors++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
      rst_n = 1'b1;
      step();
   endtask

   // Back-to-back stream of every format, one per clock, with out_ready held high
   task automatic test_formats();
      v_instr[0]  = 32'hFFF00093; v_imm[0]  = 64'hFFFF_FFFF_FFFF_FFFF; v_fmt[0]  = FMT_I;     v_ill[0]  = 1'b0;
      v_instr[1]  = 32'h7FF00093; v_imm[1]  = 64'h0000_0000_0000_07FF; v_fmt[1]  = FMT_I;     v_ill[1]  = 1'b0;
      v_instr[2]  = 32'hFE000EE3; v_imm[2]  = 64'hFFFF_FFFF_FFFF_FFFC; v_fmt[2]  = FMT_B;     v_ill[2]  = 1'b0;
      v_instr[3]  = 32'h0040006F; v_imm[3]  = 64'h0000_0000_0000_0004; v_fmt[3]  = FMT_J;     v_ill[3]  = 1'b0;
      v_instr[4]  = 32'h800000B7; v_imm[4]  = 64'hFFFF_FFFF_8000_0000; v_fmt[4]  = FMT_U;     v_ill[4]  = 1'b0;
      v_instr[5]  = 32'h12345097; v_imm[5]  = 64'h0000_0000_1234_5000; v_fmt[5]  = FMT_U;     v_ill[5]  = 1'b0;
      v_instr[6]  = 32'h03F09093; v_imm[6]  = 64'h0000_0000_0000_003F; v_fmt[6]  = FMT_SHAMT; v_ill[6]  = 1'b0;
      v_instr[7]  = 32'h41F0D09B; v_imm[7]  = 64'h0000_0000_0000_001F; v_fmt[7]  = FMT_SHAMT; v_ill[7]  = 1'b0;
      v_instr[8]  = 32'hFE112C23; v_imm[8]  = 64'hFFFF_FFFF_FFFF_FFF8; v_fmt[8]  = FMT_S;     v_ill[8]  = 1'b0;
      v_instr[9]  = 32'h3002D073; v_imm[9]  = 64'h0000_0000_0000_0005; v_fmt[9]  = FMT_Z;     v_ill[9]  = 1'b0;
      v_instr[10] = 32'h30009073; v_imm[10] = 64'h0000_0000_0000_0000; v_fmt[10] = FMT_NONE;  v_ill[10] = 1'b0;
      v_instr[11] = 32'h0000007F; v_imm[11] = 64'h0000_0000_0000_0000; v_fmt[11] = FMT_NONE;  v_ill[11] = 1'b1;
      v_instr[12] = 32'h00000000; v_imm[12] = 64'h0000_0000_0000_0000; v_fmt[12] = FMT_NONE;  v_ill[12] = 1'b1;
`ifdef IMM_GEN_RVC_EN
      v_instr[13] = 32'h000050FD; v_imm[13] = 64'hFFFF_FFFF_FFFF_FFFF; v_fmt[13] = FMT_C;     v_ill[13] = 1'b0;
`else
      v_instr[13] = 32'h000050FD; v_imm[13] = 64'h0000_0000_0000_0000; v_fmt[13] = FMT_NONE;  v_ill[13] = 1'b1;
`endif
      out_ready = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         in_valid = 1'b1;
         in_instr = v_instr[i];
         in_tag   = 8'h40 + 8'(i);
         step();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt_valid[%0d] got=%0b exp=1", i, out_valid); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fmt_in_ready[%0d] got=%0b exp=1", i, in_ready); end
         checks++; if (out_imm !== v_imm[i]) begin errors++; $display("FAIL fmt_imm[%0d] instr=%h got=%h exp=%h", i, v_instr[i], out_imm, v_imm[i]); end
         checks++; if (out_fmt !== v_fmt[i]) begin errors++; $display("FAIL fmt_fmt[%0d] instr=%h got=%0d exp=%0d", i, v_instr[i], out_fmt, v_fmt[i]); end
         checks++; if (out_illegal !== v_ill[i]) begin errors++; $display("FAIL fmt_illegal[%0d] instr=%h got=%0b exp=%0b", i, v_instr[i], out_illegal, v_ill[i]); end
         checks++; if (out_tag !== 8'h40 + 8'(i)) begin errors++; $display("FAIL fmt_tag[%0d] got=%h exp=%h", i, out_tag, 8'h40 + 8'(i)); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt_drain got=%0b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 8'd10;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got=%0b exp=1", in_ready); end
      in_instr = 32'h00200093; in_tag = 8'd11;
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_two got=%0b exp=0", in_ready); end
      checks++; if (out_tag !== 8'd10) begin errors++; $display("FAIL bp_head_tag got=%0d exp=10", out_tag); end
      in_instr = 32'h00300093; in_tag = 8'd12;
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall got=%0b exp=0", in_ready); end
      checks++; if (out_tag !== 8'd10 || out_imm !== 64'd1) begin errors++; $display("FAIL bp_stable tag=%0d imm=%h exp tag=10 imm=1", out_tag, out_imm); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_tag !== 8'd11 || out_imm !== 64'd2) begin errors++; $display("FAIL bp_second valid=%0b tag=%0d imm=%h exp 1/11/2", out_valid, out_tag, out_imm); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen got=%0b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_tag !== 8'd12 || out_imm !== 64'd3) begin errors++; $display("FAIL bp_third valid=%0b tag=%0d imm=%h exp 1/12/3", out_valid, out_tag, out_imm); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%0b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 8'd20;
      step();
      in_tag = 8'd21;
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_two got=%0b exp=0", in_ready); end
      in_tag = 8'd22; flush_i = 1'b1;
      step();
      flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
      checks++; if (out_tag !== 8'd20) begin errors++; $display("FAIL flush_fields_held got=%0d exp=20", out_tag); end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak[%0d] tag=%0d valid=%0b exp=0", k, out_tag, out_valid); end
      end
      in_valid = 1'b1; in_instr = 32'h00400093; in_tag = 8'd23;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_tag !== 8'd23 || out_imm !== 64'd4) begin errors++; $display("FAIL flush_recover valid=%0b tag=%0d imm=%h exp 1/23/4", out_valid, out_tag, out_imm); end
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 8'd30;
      step();
      in_tag = 8'd31;
      step();
      in_tag = 8'd32; rst_n = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_handshake valid=%0b ready=%0b exp 0/1", out_valid, in_ready); end
      checks++; if (out_imm !== 64'd0 || out_fmt !== FMT_NONE || out_illegal !== 1'b0 || out_tag !== 8'd0) begin
         errors++; $display("FAIL rstmid_fields imm=%h fmt=%0d ill=%0b tag=%0d exp all 0", out_imm, out_fmt, out_illegal, out_tag);
      end
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_leak[%0d] got=%0b exp=0", k, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_formats();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
